// File: rtl/id_pkg.sv
// id_pkg: opcodes, instruction field positions and the control bundle shared by ID and EX
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 6;
    localparam int RS_LSB  = 6;
    localparam int RT_LSB  = 11;
    localparam int RD_LSB  = 16;
    localparam int IMM_LSB = 16;
    localparam int IMM_W   = 16;
    localparam int TGT_LSB = 6;
    localparam int TGT_W   = 26;

    typedef struct packed {
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic reg_dst;
        logic reg_write;
        logic branch;
        logic jump;
        logic illegal;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [OPC_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_ADDI, OP_ANDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_BEQ:  c.branch  = 1'b1;
            OP_J:    c.jump    = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // Only these formats consume rt as a source operand; the rest use it as a destination or ignore it
    function automatic logic reads_rt(input logic [OPC_W-1:0] op);
        return op == OP_RTYPE || op == OP_SW || op == OP_BEQ;
    endfunction

    // ANDI is the only zero-extending format; everything else sign-extends
    function automatic logic sign_ext(input logic [OPC_W-1:0] op);
        return op != OP_ANDI;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// regfile_bypass: NREG x XLEN register file, two async reads with write-back bypass, r0 reads 0
module regfile_bypass
    import id_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int RIDX = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [RIDX-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RIDX-1:0] raddr_a,
    input  logic [RIDX-1:0] raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] regs [NREG];

    // Synchronous write port; r0 is never written so it stays at its reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : (we && waddr == raddr_a) ? wdata : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : (we && waddr == raddr_b) ? wdata : regs[raddr_b];

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: pipelined decode stage with bypassed register read, load-use stall and ID/EX register
module id_stage_pipe
    import id_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int RIDX = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instruction,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [RIDX-1:0] wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_val_a,
    output logic [XLEN-1:0] ex_val_b,
    output logic [XLEN-1:0] ex_imm,
    output logic [RIDX-1:0] ex_rt,
    output logic [RIDX-1:0] ex_rd,
    output logic [XLEN-1:0] ex_target,
    output logic            ex_mem_to_reg,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic            ex_reg_dst,
    output logic            ex_reg_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_illegal
);

    typedef struct packed {
        logic            valid;
        ctrl_t           ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] val_a;
        logic [XLEN-1:0] val_b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [RIDX-1:0] rt;
        logic [RIDX-1:0] rd;
    } idex_t;

    logic [OPC_W-1:0] opcode;
    logic [RIDX-1:0]  rs, rt, rd;
    logic [IMM_W-1:0] imm;
    logic [XLEN-1:0]  rd_a, rd_b;
    logic             load;
    idex_t            ex_d, ex_q;

    assign opcode = instruction[OPC_LSB +: OPC_W];
    assign rs     = instruction[RS_LSB +: RIDX];
    assign rt     = instruction[RT_LSB +: RIDX];
    assign rd     = instruction[RD_LSB +: RIDX];
    assign imm    = instruction[IMM_LSB +: IMM_W];

    regfile_bypass #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    // Load-use hazard against the load sitting in ID/EX; a flush overrides it so fetch can redirect
    always_comb begin
        id_stall = !flush && in_valid && ex_q.valid && ex_q.ctrl.mem_to_reg && ex_q.rt != '0 &&
                   (ex_q.rt == rs || (ex_q.rt == rt && reads_rt(opcode)));
        load     = in_valid && !flush && !id_stall;
    end

    // Decoded record for the instruction currently in ID
    always_comb begin
        ex_d        = '0;
        ex_d.valid  = 1'b1;
        ex_d.ctrl   = decode_ctrl(opcode);
        ex_d.pc     = pc_in;
        ex_d.val_a  = rd_a;
        ex_d.val_b  = rd_b;
        ex_d.imm    = {{(XLEN-IMM_W){imm[IMM_W-1] & sign_ext(opcode)}}, imm};
        ex_d.target = {pc_in[XLEN-1:28], instruction[TGT_LSB +: TGT_W], 2'b00};
        ex_d.rt     = rt;
        ex_d.rd     = rd;
    end

    // ID/EX register: flush, stall and idle all load an all-zero bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= load ? ex_d : '0;
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_val_a      = ex_q.val_a;
    assign ex_val_b      = ex_q.val_b;
    assign ex_imm        = ex_q.imm;
    assign ex_rt         = ex_q.rt;
    assign ex_rd         = ex_q.rd;
    assign ex_target     = ex_q.target;
    assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
    assign ex_mem_write  = ex_q.ctrl.mem_write;
    assign ex_alu_src    = ex_q.ctrl.alu_src;
    assign ex_reg_dst    = ex_q.ctrl.reg_dst;
    assign ex_reg_write  = ex_q.ctrl.reg_write;
    assign ex_branch     = ex_q.ctrl.branch;
    assign ex_jump       = ex_q.ctrl.jump;
    assign ex_illegal    = ex_q.ctrl.illegal;

endmodule
